plru_tree_ctrl: RTL and testbench

Parametrised tree pseudo-LRU replacement controller for set-associative caches. It holds one (NUM_WAYS-1)-bit tree state per set and updates it on every accepted hit or fill. It selects a victim way, and an invalid way in the addressed set always takes priority over the tree's choice. A sequential flush engine clears the state array one set per cycle. The block sits beside the cache tag array and is driven by the cache controller's lookup stage.

---
 rtl/plru_pkg.sv | 17 +
 rtl/plru_tree_ctrl_if.sv | 28 ++
 rtl/plru_tree_next.sv | 57 +++++
 rtl/plru_tree_ctrl.sv | 67 ++++++
 tb/tb_plru_tree_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/plru_pkg.sv
// plru_pkg: shared sizing helper, default geometry and flush FSM encoding
package plru_pkg;

    localparam int DEF_NUM_SETS = 64;
    localparam int DEF_NUM_WAYS = 4;
    localparam int TREE_W       = DEF_NUM_WAYS - 1;

    typedef enum logic {IDLE, SWEEP} flush_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/plru_tree_ctrl_if.sv
// plru_tree_ctrl_if: lookup-stage access, flush and victim signals of the PLRU controller
interface plru_tree_ctrl_if import plru_pkg::*; #(
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    localparam int SET_W = clog2(NUM_SETS),
    localparam int WAY_W = clog2(NUM_WAYS)
);
    logic                acc_valid;
    logic [SET_W-1:0]    acc_set;
    logic                acc_hit;
    logic [NUM_WAYS-1:0] acc_way;
    logic [NUM_WAYS-1:0] valid_mask;
    logic                flush_req;
    logic                busy;
    logic [NUM_WAYS-1:0] repl_way;
    logic [WAY_W-1:0]    repl_idx;
    logic                repl_from_invalid;

    modport master (
        output acc_valid, acc_set, acc_hit, acc_way, valid_mask, flush_req,
        input  busy, repl_way, repl_idx, repl_from_invalid
    );

    modport slave (
        input  acc_valid, acc_set, acc_hit, acc_way, valid_mask, flush_req,
        output busy, repl_way, repl_idx, repl_from_invalid
    );
endinterface

// File: rtl/plru_tree_next.sv
// plru_tree_next: victim selection and promoted next tree state for one set
module plru_tree_next import plru_pkg::*; #(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    localparam int WAY_W = clog2(NUM_WAYS),
    localparam int TW = NUM_WAYS - 1
) (
    input  logic [TW-1:0]       tree_i,
    input  logic [NUM_WAYS-1:0] valid_mask_i,
    input  logic [NUM_WAYS-1:0] promote_way_i,
    input  logic                hit_i,
    output logic [NUM_WAYS-1:0] victim_way_o,
    output logic [WAY_W-1:0]    victim_idx_o,
    output logic                from_invalid_o,
    output logic [TW-1:0]       tree_o
);
    logic [WAY_W-1:0] tree_idx, inv_idx, hit_idx, prom_idx;
    logic [TW-1:0]    promoted;

    // Follow node bits from the root; each level contributes one index bit, MSB first
    always_comb begin
        int node;
        node = 0;
        tree_idx = '0;
        for (int l = 0; l < WAY_W; l++) begin
            tree_idx[WAY_W-1-l] = 1'(tree_i >> node);
            node = 2 * node + 1 + int'(tree_idx[WAY_W-1-l]);
        end
    end

    // Lowest-index invalid way and binary index of the one-hot hit way
    always_comb begin
        inv_idx = '0;
        hit_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) if (!valid_mask_i[i]) inv_idx = WAY_W'(i);
        for (int i = 0; i < NUM_WAYS; i++) if (promote_way_i[i]) hit_idx = hit_idx | WAY_W'(i);
    end

    assign from_invalid_o = ~&valid_mask_i;
    assign victim_idx_o   = from_invalid_o ? inv_idx : tree_idx;
    assign victim_way_o   = NUM_WAYS'(1) << victim_idx_o;
    assign prom_idx       = hit_i ? hit_idx : victim_idx_o;

    // Point every node on the path to the promoted way towards the other subtree
    always_comb begin
        int node;
        node = 0;
        promoted = tree_i;
        for (int l = 0; l < WAY_W; l++) begin
            promoted = prom_idx[WAY_W-1-l] ? (promoted & ~(TW'(1) << node)) : (promoted | (TW'(1) << node));
            node = 2 * node + 1 + int'(prom_idx[WAY_W-1-l]);
        end
    end

    // A hit with a zero or multi-hot way leaves the set untouched
    assign tree_o = (hit_i && !$onehot(promote_way_i)) ? tree_i : promoted;

endmodule

// File: rtl/plru_tree_ctrl.sv
// plru_tree_ctrl: per-set tree pseudo-LRU state array with victim select and flush sweep
module plru_tree_ctrl import plru_pkg::*; #(
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    localparam int SET_W = clog2(NUM_SETS),
    localparam int TW = NUM_WAYS - 1
) (
    input logic             clk,
    input logic             reset,
    plru_tree_ctrl_if.slave bus
);
    logic [TW-1:0]    state_q [NUM_SETS];
    logic [TW-1:0]    tree_cur, tree_nx;
    flush_state_e     fsm_q, fsm_d;
    logic [SET_W-1:0] ptr_q, ptr_d;
    logic             accept;

    assign tree_cur = state_q[bus.acc_set];
    assign accept   = bus.acc_valid && fsm_q == IDLE;
    assign bus.busy = fsm_q == SWEEP;

    plru_tree_next #(.NUM_WAYS(NUM_WAYS)) u_next (
        .tree_i        (tree_cur),
        .valid_mask_i  (bus.valid_mask),
        .promote_way_i (bus.acc_way),
        .hit_i         (bus.acc_hit),
        .victim_way_o  (bus.repl_way),
        .victim_idx_o  (bus.repl_idx),
        .from_invalid_o(bus.repl_from_invalid),
        .tree_o        (tree_nx)
    );

    // Sweep walks ptr over every set once, then falls back to IDLE with ptr wrapped to 0
    always_comb begin
        fsm_d = fsm_q;
        ptr_d = ptr_q;
        if (fsm_q == IDLE) begin
            fsm_d = bus.flush_req ? SWEEP : IDLE;
        end else begin
            ptr_d = ptr_q + 1'b1;
            fsm_d = (ptr_q == SET_W'(NUM_SETS - 1)) ? IDLE : SWEEP;
        end
    end

    // Flush FSM and sweep pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= IDLE;
            ptr_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            ptr_q <= ptr_d;
        end
    end

    // State array: reset clears all sets, sweep clears one set, accepted access writes the promoted tree
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) state_q[s] <= '0;
        end else if (fsm_q == SWEEP) begin
            state_q[ptr_q] <= '0;
        end else if (accept) begin
            state_q[bus.acc_set] <= tree_nx;
        end
    end

endmodule

// File: tb/tb_plru_tree_ctrl.sv
// tb_plru_tree_ctrl: directed checks of the 4-way/64-set controller plus an 8-way model comparison
module tb_plru_tree_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plru_tree_ctrl_if #(.NUM_SETS(64), .NUM_WAYS(4)) a ();
    plru_tree_ctrl_if #(.NUM_SETS(2),  .NUM_WAYS(8)) b ();

    plru_tree_ctrl #(.NUM_SETS(64), .NUM_WAYS(4)) dut (.clk(clk), .reset(reset), .bus(a.slave));
    plru_tree_ctrl #(.NUM_SETS(2),  .NUM_WAYS(8)) dut8 (.clk(clk), .reset(reset), .bus(b.slave));

    always @(posedge clk) begin
        if (!reset && a.acc_valid && a.acc_hit) assert ($onehot(a.acc_way)) else $error("illegal acc_way on 4-way bus");
        if (!reset && b.acc_valid && b.acc_hit) assert ($onehot(b.acc_way)) else $error("illegal acc_way on 8-way bus");
    end

    task automatic drive(input logic v, input int s, input logic h, input logic [3:0] w, input logic [3:0] vm, input logic fr);
        @(negedge clk);
        a.acc_valid = v; a.acc_set = 6'(s); a.acc_hit = h; a.acc_way = w; a.valid_mask = vm; a.flush_req = fr;
        #1;
    endtask

    task automatic look(input int s);
        drive(1'b0, s, 1'b0, 4'b0000, 4'b1111, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        look(5);
        look(5);
        checks++; if (a.repl_way !== 4'b0001) begin errors++; $display("FAIL reset_way got %b want 0001", a.repl_way); end
        checks++; if (a.repl_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", a.repl_idx); end
        checks++; if (a.repl_from_invalid !== 1'b0) begin errors++; $display("FAIL reset_inv got %b want 0", a.repl_from_invalid); end
        checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a.busy); end
        drive(1'b0, 5, 1'b0, 4'b0000, 4'b1101, 1'b0);
        checks++; if (a.repl_way !== 4'b0010 || a.repl_from_invalid !== 1'b1) begin errors++; $display("FAIL reset_invalid got %b/%b want 0010/1", a.repl_way, a.repl_from_invalid); end
        reset = 1'b0;
    endtask

    task automatic test_hit_promotion();
        drive(1'b1, 5, 1'b1, 4'b0001, 4'b1111, 1'b0);
        look(5);
        checks++; if (a.repl_way !== 4'b0100) begin errors++; $display("FAIL hit_w0 got %b want 0100", a.repl_way); end
        drive(1'b1, 5, 1'b1, 4'b0100, 4'b1111, 1'b0);
        look(5);
        checks++; if (a.repl_way !== 4'b0010 || a.repl_idx !== 2'd1) begin errors++; $display("FAIL hit_w2 got %b/%0d want 0010/1", a.repl_way, a.repl_idx); end
    endtask

    task automatic test_invalid_miss();
        drive(1'b1, 3, 1'b0, 4'b0000, 4'b1011, 1'b0);
        checks++; if (a.repl_way !== 4'b0100 || a.repl_idx !== 2'd2 || a.repl_from_invalid !== 1'b1) begin
            errors++; $display("FAIL inv_sel got %b/%0d/%b want 0100/2/1", a.repl_way, a.repl_idx, a.repl_from_invalid);
        end
        look(3);
        checks++; if (a.repl_way !== 4'b0001 || a.repl_from_invalid !== 1'b0) begin errors++; $display("FAIL inv_promote got %b/%b want 0001/0", a.repl_way, a.repl_from_invalid); end
    endtask

    task automatic test_fill();
        logic [3:0] exp [4];
        int sets [2];
        exp = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
        sets = '{0, 63};
        foreach (sets[j]) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, sets[j], 1'b0, 4'b0000, 4'b1111, 1'b0);
                checks++; if (a.repl_way !== exp[k]) begin errors++; $display("FAIL fill_s%0d_%0d got %b want %b", sets[j], k, a.repl_way, exp[k]); end
            end
            look(sets[j]);
            checks++; if (a.repl_way !== 4'b0001) begin errors++; $display("FAIL fill_wrap_s%0d got %b want 0001", sets[j], a.repl_way); end
        end
        look(5);
        checks++; if (a.repl_way !== 4'b0010) begin errors++; $display("FAIL set_isolation got %b want 0010", a.repl_way); end
    endtask

    task automatic test_flush();
        int n;
        bit done;
        drive(1'b1, 0, 1'b1, 4'b0001, 4'b1111, 1'b0);
        drive(1'b1, 31, 1'b1, 4'b0001, 4'b1111, 1'b0);
        drive(1'b1, 63, 1'b1, 4'b0001, 4'b1111, 1'b0);
        look(31);
        checks++; if (a.repl_way !== 4'b0100) begin errors++; $display("FAIL flush_dirty got %b want 0100", a.repl_way); end
        drive(1'b0, 0, 1'b0, 4'b0000, 4'b1111, 1'b1);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            drive(1'b1, 10, 1'b1, 4'b0001, 4'b1111, i == 20);
            if (!a.busy) begin
                a.acc_valid = 1'b0;
                done = 1'b1;
            end else n++;
        end
        checks++; if (!done || n != 64) begin errors++; $display("FAIL flush_busy_len got %0d want 64", n); end
        for (int s = 0; s < 64; s++) begin
            look(s);
            checks++; if (a.repl_way !== 4'b0001) begin errors++; $display("FAIL flush_clear_s%0d got %b want 0001", s, a.repl_way); end
        end
    endtask

    task automatic test_flush_with_hit();
        bit done;
        drive(1'b1, 0, 1'b1, 4'b0001, 4'b1111, 1'b1);
        look(0);
        checks++; if (a.busy !== 1'b1) begin errors++; $display("FAIL fh_busy got %b want 1", a.busy); end
        checks++; if (a.repl_way !== 4'b0100) begin errors++; $display("FAIL fh_applied got %b want 0100", a.repl_way); end
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            look(0);
            if (!a.busy) done = 1'b1;
        end
        checks++; if (!done || a.repl_way !== 4'b0001) begin errors++; $display("FAIL fh_cleared got %b/%b want 0001/1", a.repl_way, done); end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 63, 1'b1, 4'b0001, 4'b1111, 1'b0);
        drive(1'b0, 0, 1'b0, 4'b0000, 4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) look(63);
        checks++; if (a.busy !== 1'b1 || a.repl_way !== 4'b0100) begin errors++; $display("FAIL abort_pre got %b/%b want 1/0100", a.busy, a.repl_way); end
        reset = 1'b1;
        look(63);
        reset = 1'b0;
        checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", a.busy); end
        for (int s = 0; s < 64; s++) begin
            look(s);
            checks++; if (a.repl_way !== 4'b0001) begin errors++; $display("FAIL abort_clear_s%0d got %b want 0001", s, a.repl_way); end
        end
    endtask

    task automatic test_8way_model();
        logic [6:0] mt [2];
        int s, w, v, p, node;
        logic [7:0] vm;
        logic miss;
        bit exp_inv;
        mt[0] = '0;
        mt[1] = '0;
        for (int c = 0; c < 10000; c++) begin
            s = int'($urandom_range(0, 1));
            w = int'($urandom_range(0, 7));
            miss = ($urandom_range(0, 3) == 0);
            vm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            exp_inv = (vm != 8'hFF);
            v = 0;
            if (exp_inv) begin
                for (int i = 7; i >= 0; i--) if (!vm[i]) v = i;
            end else begin
                for (int l = 0; l < 3; l++) begin
                    node = (1 << l) - 1 + v;
                    v = (v << 1) | int'(mt[s][node]);
                end
            end
            @(negedge clk);
            b.acc_valid = 1'b1; b.acc_set = 1'(s); b.acc_hit = !miss; b.acc_way = 8'(1 << w); b.valid_mask = vm; b.flush_req = 1'b0;
            #1;
            checks++; if (b.repl_idx !== 3'(v) || b.repl_from_invalid !== exp_inv || b.repl_way !== 8'(1 << v)) begin
                errors++; $display("FAIL w8_c%0d got %0d/%b/%b want %0d/%b", c, b.repl_idx, b.repl_from_invalid, b.repl_way, v, exp_inv);
            end
            p = miss ? v : w;
            for (int l = 0; l < 3; l++) begin
                node = (1 << l) - 1 + (p >> (3 - l));
                mt[s][node] = !((p >> (2 - l)) & 1);
            end
        end
        @(negedge clk);
        b.acc_valid = 1'b0;
    endtask

    initial begin
        a.acc_valid = 1'b0; a.acc_set = '0; a.acc_hit = 1'b0; a.acc_way = '0; a.valid_mask = '1; a.flush_req = 1'b0;
        b.acc_valid = 1'b0; b.acc_set = '0; b.acc_hit = 1'b0; b.acc_way = '0; b.valid_mask = '1; b.flush_req = 1'b0;
        test_reset();
        test_hit_promotion();
        test_invalid_miss();
        test_fill();
        test_flush();
        test_flush_with_hit();
        test_reset_abort();
        test_8way_model();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
